magnet_sequencer: RTL and testbench



---
 rtl/magnet_sequencer_if.sv | 24 ++
 rtl/magnet_sequencer.sv | 136 +++++++++++++
 tb/tb_magnet_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/magnet_sequencer_if.sv
// Command/feedback bundle between the move FSM, magnet_sequencer and the magnet state holder.
// master = surrounding logic (commands + holder feedback), slave = the sequencer.
interface magnet_sequencer_if;
  logic cmd_grab;
  logic cmd_release;
  logic magnet_state;
  logic magnet_on;
  logic magnet_off;
  logic holding;
  logic busy;
  logic done;
  logic timeout;
  logic fault;

  modport master (
    output cmd_grab, cmd_release, magnet_state,
    input  magnet_on, magnet_off, holding, busy, done, timeout, fault
  );

  modport slave (
    input  cmd_grab, cmd_release, magnet_state,
    output magnet_on, magnet_off, holding, busy, done, timeout, fault
  );
endinterface

// File: rtl/magnet_sequencer.sv
// Grab/release sequencer: pulses the holder, settles, checks feedback, watchdogs HOLD.
// Latency cmd -> done is 2+SETTLE_CYCLES; no backpressure, commands outside IDLE_OFF/HOLD are dropped.
module magnet_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 500000,
  parameter int unsigned MAX_ON_CYCLES = 250000000,
  parameter int unsigned CNT_W         = 28
) (
  input  logic               clk,
  input  logic               reset,
  magnet_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE_OFF   = 3'd0,
    ENERGISE   = 3'd1,
    SETTLE_ON  = 3'd2,
    HOLD       = 3'd3,
    DEENERGISE = 3'd4,
    SETTLE_OFF = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] MAX_ON_LAST = CNT_W'(MAX_ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             pending;

  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE_OFF;
      cnt            <= '0;
      pending        <= 1'b0;
      bus.magnet_on  <= 1'b0;
      // Holder has no reset of its own; keep commanding it off.
      bus.magnet_off <= 1'b1;
      bus.holding    <= 1'b0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.timeout    <= 1'b0;
      bus.fault      <= 1'b0;
    end else begin
      bus.magnet_on  <= 1'b0;
      bus.magnet_off <= 1'b0;
      bus.done       <= 1'b0;

      case (state)
        IDLE_OFF: begin
          // Simultaneous grab+release resolves to release, which is a no-op here.
          if (bus.cmd_grab && !bus.cmd_release) begin
            state         <= ENERGISE;
            bus.magnet_on <= 1'b1;
            bus.busy      <= 1'b1;
            bus.timeout   <= 1'b0;
            bus.fault     <= 1'b0;
          end
        end

        ENERGISE: begin
          state <= SETTLE_ON;
          cnt   <= '0;
          if (bus.cmd_release) pending <= 1'b1;
        end

        SETTLE_ON: begin
          if (bus.cmd_release) pending <= 1'b1;
          if (cnt == SETTLE_LAST) begin
            if (bus.magnet_state) begin
              state          <= DEENERGISE;
              bus.magnet_off <= 1'b1;
              bus.fault      <= 1'b1;
              pending        <= 1'b0;
            end else begin
              state       <= HOLD;
              cnt         <= '0;
              bus.done    <= 1'b1;
              bus.holding <= 1'b1;
              bus.busy    <= 1'b0;
            end
          end else begin
            cnt <= cnt_inc;
          end
        end

        HOLD: begin
          // A release (live or pending) outranks the watchdog in the same cycle.
          if (bus.cmd_release || pending) begin
            state          <= DEENERGISE;
            bus.magnet_off <= 1'b1;
            bus.holding    <= 1'b0;
            bus.busy       <= 1'b1;
            pending        <= 1'b0;
          end else if (cnt == MAX_ON_LAST) begin
            state          <= DEENERGISE;
            bus.magnet_off <= 1'b1;
            bus.holding    <= 1'b0;
            bus.busy       <= 1'b1;
            bus.timeout    <= 1'b1;
            pending        <= 1'b0;
          end else begin
            cnt <= cnt_inc;
          end
        end

        DEENERGISE: begin
          state <= SETTLE_OFF;
          cnt   <= '0;
        end

        SETTLE_OFF: begin
          if (cnt == SETTLE_LAST) begin
            state    <= IDLE_OFF;
            bus.done <= 1'b1;
            bus.busy <= 1'b0;
          end else begin
            cnt <= cnt_inc;
          end
        end

        default: begin
          state          <= IDLE_OFF;
          cnt            <= '0;
          pending        <= 1'b0;
          bus.magnet_off <= 1'b1;
          bus.holding    <= 1'b0;
          bus.busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_magnet_sequencer.sv
// Directed bench for magnet_sequencer with SETTLE_CYCLES=4, MAX_ON_CYCLES=20 and a 1-cycle holder model.
module tb_magnet_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic holder_q = 1'b1;
  logic stuck = 1'b0;
  int tests = 0;
  int failed = 0;

  magnet_sequencer_if bus ();

  magnet_sequencer #(
    .SETTLE_CYCLES(4),
    .MAX_ON_CYCLES(20),
    .CNT_W(28)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.magnet_on === 1'b1) holder_q <= 1'b0;
    else if (bus.magnet_off === 1'b1) holder_q <= 1'b1;
  end

  assign bus.magnet_state = stuck | holder_q;

  // {magnet_on, magnet_off, holding, busy, done, timeout, fault}
  function automatic logic [6:0] outs();
    return {bus.magnet_on, bus.magnet_off, bus.holding, bus.busy,
            bus.done, bus.timeout, bus.fault};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Plain stimulus: from HOLD, release and run to one cycle past the done pulse.
  task automatic release_to_idle();
    bus.cmd_release = 1'b1;
    step();
    bus.cmd_release = 1'b0;
    repeat (6) step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.cmd_grab = 1'b0;
    bus.cmd_release = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      tests++;
      if (outs() !== 7'b0100000) begin
        failed++;
        $display("FAIL reset_outs cyc%0d got %b want %b", i, outs(), 7'b0100000);
      end
      tests++;
      if (bus.magnet_state !== 1'b1) begin
        failed++;
        $display("FAIL reset_holder cyc%0d got %b want 1", i, bus.magnet_state);
      end
    end
    reset = 1'b0;
    step();
    tests++;
    if (outs() !== 7'b0000000) begin
      failed++;
      $display("FAIL reset_release got %b want %b", outs(), 7'b0000000);
    end
  endtask

  task automatic test_grab();
    logic [6:0] exp;
    bus.cmd_grab = 1'b1;
    step();
    bus.cmd_grab = 1'b0;
    for (int i = 0; i < 6; i++) begin
      case (i)
        0:       exp = 7'b1001000;
        5:       exp = 7'b0010100;
        default: exp = 7'b0001000;
      endcase
      tests++;
      if (outs() !== exp) begin
        failed++;
        $display("FAIL grab n+%0d got %b want %b", i + 1, outs(), exp);
      end
      if (i < 5) step();
    end
    tests++;
    if (bus.magnet_state !== 1'b0) begin
      failed++;
      $display("FAIL grab_holder got %b want 0", bus.magnet_state);
    end
  endtask

  task automatic test_release();
    logic [6:0] exp;
    for (int i = 0; i < 4; i++) begin
      step();
      tests++;
      if (outs() !== 7'b0010000) begin
        failed++;
        $display("FAIL hold_steady cyc%0d got %b want %b", i, outs(), 7'b0010000);
      end
    end
    bus.cmd_release = 1'b1;
    step();
    bus.cmd_release = 1'b0;
    for (int i = 0; i < 7; i++) begin
      case (i)
        0:       exp = 7'b0101000;
        5:       exp = 7'b0000100;
        6:       exp = 7'b0000000;
        default: exp = 7'b0001000;
      endcase
      tests++;
      if (outs() !== exp) begin
        failed++;
        $display("FAIL release n+%0d got %b want %b", i + 1, outs(), exp);
      end
      if (i < 6) step();
    end
    tests++;
    if (bus.magnet_state !== 1'b1) begin
      failed++;
      $display("FAIL release_holder got %b want 1", bus.magnet_state);
    end
  endtask

  task automatic test_timeout();
    logic [6:0] exp;
    bus.cmd_grab = 1'b1;
    step();
    bus.cmd_grab = 1'b0;
    repeat (5) step();
    tests++;
    if (outs() !== 7'b0010100) begin
      failed++;
      $display("FAIL to_hold_entry got %b want %b", outs(), 7'b0010100);
    end
    for (int k = 1; k <= 25; k++) begin
      step();
      if (k < 20)       exp = 7'b0010000;
      else if (k == 20) exp = 7'b0101010;
      else if (k < 25)  exp = 7'b0001010;
      else              exp = 7'b0000110;
      tests++;
      if (outs() !== exp) begin
        failed++;
        $display("FAIL timeout h+%0d got %b want %b", k, outs(), exp);
      end
    end
    step();
    bus.cmd_grab = 1'b1;
    step();
    bus.cmd_grab = 1'b0;
    tests++;
    if (outs() !== 7'b1001000) begin
      failed++;
      $display("FAIL timeout_clear got %b want %b", outs(), 7'b1001000);
    end
    repeat (5) step();
    release_to_idle();
  endtask

  task automatic test_fault();
    logic [6:0] exp;
    stuck = 1'b1;
    bus.cmd_grab = 1'b1;
    step();
    bus.cmd_grab = 1'b0;
    for (int i = 0; i < 11; i++) begin
      case (i)
        0:       exp = 7'b1001000;
        1, 2, 3, 4: exp = 7'b0001000;
        5:       exp = 7'b0101001;
        10:      exp = 7'b0000101;
        default: exp = 7'b0001001;
      endcase
      tests++;
      if (outs() !== exp) begin
        failed++;
        $display("FAIL fault n+%0d got %b want %b", i + 1, outs(), exp);
      end
      if (i < 10) step();
    end
    stuck = 1'b0;
    step();
  endtask

  task automatic test_edge();
    logic [6:0] exp;
    // Grab and release together in IDLE_OFF: nothing happens, fault stays sticky.
    bus.cmd_grab = 1'b1;
    bus.cmd_release = 1'b1;
    step();
    bus.cmd_grab = 1'b0;
    bus.cmd_release = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (outs() !== 7'b0000001) begin
        failed++;
        $display("FAIL both_cmds cyc%0d got %b want %b", i, outs(), 7'b0000001);
      end
      step();
    end

    // Release during SETTLE_ON.
    bus.cmd_grab = 1'b1;
    step();
    bus.cmd_grab = 1'b0;
    tests++;
    if (outs() !== 7'b1001000) begin
      failed++;
      $display("FAIL pend_energise got %b want %b", outs(), 7'b1001000);
    end
    step();
    bus.cmd_release = 1'b1;
    step();
    bus.cmd_release = 1'b0;
    repeat (3) step();
    tests++;
    if (outs() !== 7'b0010100) begin
      failed++;
      $display("FAIL pend_hold_entry got %b want %b", outs(), 7'b0010100);
    end
    step();
    tests++;
    if (outs() !== 7'b0101000) begin
      failed++;
      $display("FAIL pend_deenergise got %b want %b", outs(), 7'b0101000);
    end
    repeat (5) step();
    tests++;
    if (outs() !== 7'b0000100) begin
      failed++;
      $display("FAIL pend_done got %b want %b", outs(), 7'b0000100);
    end
    step();

    // Release on the watchdog's last cycle wins: no timeout.
    bus.cmd_grab = 1'b1;
    step();
    bus.cmd_grab = 1'b0;
    repeat (5) step();
    repeat (19) step();
    tests++;
    if (outs() !== 7'b0010000) begin
      failed++;
      $display("FAIL race_last_hold got %b want %b", outs(), 7'b0010000);
    end
    bus.cmd_release = 1'b1;
    step();
    bus.cmd_release = 1'b0;
    tests++;
    if (outs() !== 7'b0101000) begin
      failed++;
      $display("FAIL race_release got %b want %b", outs(), 7'b0101000);
    end
    repeat (6) step();

    // Reset while holding.
    bus.cmd_grab = 1'b1;
    step();
    bus.cmd_grab = 1'b0;
    repeat (6) step();
    tests++;
    if (outs() !== 7'b0010000) begin
      failed++;
      $display("FAIL rst_pre_hold got %b want %b", outs(), 7'b0010000);
    end
    reset = 1'b1;
    step();
    tests++;
    if (outs() !== 7'b0100000) begin
      failed++;
      $display("FAIL rst_in_hold got %b want %b", outs(), 7'b0100000);
    end
    reset = 1'b0;
    step();
    for (int i = 0; i < 2; i++) begin
      exp = 7'b0000000;
      tests++;
      if (outs() !== exp) begin
        failed++;
        $display("FAIL rst_after cyc%0d got %b want %b", i, outs(), exp);
      end
      step();
    end
    tests++;
    if (bus.magnet_state !== 1'b1) begin
      failed++;
      $display("FAIL rst_holder got %b want 1", bus.magnet_state);
    end
  endtask

  initial begin
    bus.cmd_grab = 1'b0;
    bus.cmd_release = 1'b0;
    test_reset();
    repeat (3) step();
    test_grab();
    test_release();
    test_timeout();
    test_fault();
    test_edge();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
